multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle main control FSM for the RV32 datapath; successor to the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives per-state datapath enables and mux selects.
- Talks to a variable-latency unified memory through a req/ready handshake, with a watchdog on that handshake.
- Adds HALT and illegal-opcode trap states and an instruction-retired counter; sits between the IR opcode field and the datapath/memory port.

Parameters:
- TIMEOUT_CYC, 64: max cycles mem_req may stay high without mem_ready before trapping.
- CNT_W, 32: width of the retired-instruction counter.
- HALT_EN, 1: 1 means opcode 7'b1111111 halts; 0 means it is treated as illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- br_taken  in  1  branch comparator result from datapath, valid in EXEC
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  write qualifier for mem_req
- mem_is_ifetch  out  1  address mux: 1 selects PC, 0 selects ALU result
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
- alu_src  out  1  0 rs2, 1 imm
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- reg_write  out  1  register file write enable
- rw_sel  out  2  00 ALU, 01 memory data, 10 PC+4
- halted  out  1  sticky, set in HALT state
- illegal  out  1  sticky, set in TRAP state
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=FETCH, every output 0, instret=0, watchdog=0. Reset mid-transaction drops mem_req immediately; no handshake completion is owed.
- Output style: all outputs are Moore, combinational from state except where noted.
- Supported opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BR 1100011, JAL 1101111, JALR 1100111, HALT 1111111. Any other opcode, or HALT with HALT_EN=0, goes to TRAP.
- FETCH:
  - Outputs: mem_req=1, mem_is_ifetch=1.
  - On mem_ready: ir_we=1 and pc_we=1 with pc_sel=00 in that same cycle (Mealy on mem_ready), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (one cycle): no enables asserted. Classify opcode:
  - HALT to HALT.
  - Illegal to TRAP.
  - Everything else to EXEC.
- EXEC (one cycle), by instruction class:
  - R: alu_src=0, alu_op=10, then WB.
  - I-ALU: alu_src=1, alu_op=10, then WB.
  - LOAD/STORE: alu_src=1, alu_op=00, then MEM.
  - BR: alu_op=01. If br_taken, pc_we=1 with pc_sel=01. Next state FETCH; instret increments.
  - JAL: reg_write=1, rw_sel=10, pc_we=1, pc_sel=01, then FETCH; instret increments.
  - JALR: alu_src=1, reg_write=1, rw_sel=10, pc_we=1, pc_sel=10, then FETCH; instret increments.
  - JAL/JALR rd write uses the PC+4 value registered at fetch, so the simultaneous PC update is safe.
- MEM:
  - Outputs: mem_req=1, mem_is_ifetch=0; mem_we=1 for STORE.
  - On mem_ready: LOAD goes to WB; STORE goes to FETCH and instret increments.
- WB (one cycle): reg_write=1; rw_sel=01 for LOAD, 00 otherwise. Then FETCH; instret increments.
- Watchdog:
  - Counts cycles while in FETCH or MEM with mem_ready=0; clears on any state change.
  - When the count reaches TIMEOUT_CYC-1 with mem_ready still 0, next state is TRAP.
  - mem_ready in that same cycle wins over the timeout.
- HALT / TRAP:
  - Terminal states; exit only via reset.
  - All enables and mem_req are 0.
  - halted=1 in HALT; illegal=1 in TRAP. These flags register on state entry (first cycle in state).
- instret:
  - Increments by 1 on the final cycle of each retired instruction.
  - Wraps modulo 2^CNT_W.
  - HALT and illegal instructions do not increment it.
- Latency (with mem_ready in the first request cycle):
  - R / I-ALU: 4 cycles.
  - BR / JAL / JALR: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Package rv_ctrl_pkg holds:
  - Opcode localparams.
  - State enum: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
  - alu_op, pc_sel and rw_sel encodings, shared with datapath muxes.
- Sub-module ctrl_opclass_decode: combinational opcode to class enum {R, IALU, LOAD, STORE, BR, JAL, JALR, HALT, ILLEGAL}, honouring HALT_EN.
- FSM, watchdog and instret counter live in the top module.

Test Plan:
- ADD (0110011), mem_ready tied 1: states F,D,E,W; reg_write=1 with rw_sel=00 only in W; instret 0 to 1 after 4 cycles.
- LW with mem_ready delayed 3 cycles in MEM: mem_req/mem_is_ifetch=0 held 4 cycles; then WB with rw_sel=01; total 8 cycles; mem_we never 1.
- BEQ: br_taken=1 gives pc_we=1, pc_sel=01 in EXEC; br_taken=0 gives pc_we=0 in EXEC; both return to FETCH, instret +1.
- JALR: in EXEC, reg_write=1, rw_sel=10, pc_sel=10, pc_we=1, all in one cycle; next state FETCH.
- FETCH with mem_ready held 0, TIMEOUT_CYC=8: TRAP after 8 request cycles; illegal=1 and mem_req=0 thereafter; mem_ready arriving on cycle 8 instead proceeds to DECODE.
- Opcode 1111111 with HALT_EN=1: halted=1 and instret unchanged. With HALT_EN=0: illegal=1. Assert rst_n=0 mid-MEM: mem_req drops asynchronously, state FETCH, flags cleared.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: opcodes, FSM states,
// instruction classes and the datapath mux selects driven by the controller.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_IALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_HALT  = 7'b1111111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_IALU    = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BR      = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } opclass_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_IMM    = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] RW_ALU    = 2'b00;
    localparam logic [1:0] RW_MEM    = 2'b01;
    localparam logic [1:0] RW_PC4    = 2'b10;

endpackage

// File: rtl/multicycle_controller_opclass_decode.sv
// Maps the IR opcode field to an instruction class; the HALT opcode is only
// recognised when HALT_EN is set, otherwise it falls into the illegal class.
module ctrl_opclass_decode
    import rv_ctrl_pkg::*;
#(
    parameter int HALT_EN = 1
) (
    input  logic [6:0] i_opcode,
    output opclass_e   o_class
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OPC_R:     o_class = CLS_R;
            OPC_IALU:  o_class = CLS_IALU;
            OPC_LOAD:  o_class = CLS_LOAD;
            OPC_STORE: o_class = CLS_STORE;
            OPC_BR:    o_class = CLS_BR;
            OPC_JAL:   o_class = CLS_JAL;
            OPC_JALR:  o_class = CLS_JALR;
            OPC_HALT:  o_class = (HALT_EN != 0) ? CLS_HALT : CLS_ILLEGAL;
            default:   o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32 datapath: sequences each instruction,
// handshakes with unified memory under a watchdog, and counts retired instructions.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 32,
    parameter int HALT_EN     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_ifetch,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       rw_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_e           r_state;
    state_e           w_state_next;
    opclass_e         r_class;
    opclass_e         w_class_dec;
    logic [WD_W-1:0]  r_wdog;
    logic [CNT_W-1:0] r_instret;
    logic             r_halted;
    logic             r_illegal;
    logic             w_wait;
    logic             w_timeout;
    logic             w_retire;

    ctrl_opclass_decode #(
        .HALT_EN (HALT_EN)
    ) u_decode (
        .i_opcode (opcode),
        .o_class  (w_class_dec)
    );

    assign w_wait    = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
    assign w_timeout = w_wait && (r_wdog == WD_LAST);

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_is_ifetch = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = PC_PLUS4;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        rw_sel        = RW_ALU;
        w_retire      = 1'b0;
        w_state_next  = r_state;

        case (r_state)
            ST_FETCH: begin
                mem_req       = 1'b1;
                mem_is_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    pc_sel       = PC_PLUS4;
                    w_state_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_next = ST_TRAP;
                end
            end
            ST_DECODE: begin
                case (w_class_dec)
                    CLS_HALT:    w_state_next = ST_HALT;
                    CLS_ILLEGAL: w_state_next = ST_TRAP;
                    default:     w_state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_R: begin
                        alu_op       = ALU_FUNCT;
                        w_state_next = ST_WB;
                    end
                    CLS_IALU: begin
                        alu_src      = 1'b1;
                        alu_op       = ALU_FUNCT;
                        w_state_next = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src      = 1'b1;
                        alu_op       = ALU_ADD;
                        w_state_next = ST_MEM;
                    end
                    CLS_BR: begin
                        alu_op       = ALU_BR;
                        if (br_taken) begin
                            pc_we  = 1'b1;
                            pc_sel = PC_IMM;
                        end
                        w_retire     = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    // rd receives the PC+4 latched at fetch, so updating PC here is safe
                    CLS_JAL: begin
                        reg_write    = 1'b1;
                        rw_sel       = RW_PC4;
                        pc_we        = 1'b1;
                        pc_sel       = PC_IMM;
                        w_retire     = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    CLS_JALR: begin
                        alu_src      = 1'b1;
                        reg_write    = 1'b1;
                        rw_sel       = RW_PC4;
                        pc_we        = 1'b1;
                        pc_sel       = PC_JALR;
                        w_retire     = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    default: w_state_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_class == CLS_STORE);
                if (mem_ready) begin
                    if (r_class == CLS_STORE) begin
                        w_retire     = 1'b1;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write    = 1'b1;
                rw_sel       = (r_class == CLS_LOAD) ? RW_MEM : RW_ALU;
                w_retire     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_HALT, ST_TRAP: begin
                w_state_next = r_state;
            end
            default: w_state_next = ST_TRAP;
        endcase

        // Reset must silence the memory port immediately, not at the next edge
        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_is_ifetch = 1'b0;
            ir_we         = 1'b0;
            pc_we         = 1'b0;
            pc_sel        = PC_PLUS4;
            alu_src       = 1'b0;
            alu_op        = ALU_ADD;
            reg_write     = 1'b0;
            rw_sel        = RW_ALU;
            w_retire      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_class   <= CLS_ILLEGAL;
            r_wdog    <= '0;
            r_instret <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_DECODE) begin
                r_class <= w_class_dec;
            end
            if (w_state_next != r_state) begin
                r_wdog <= '0;
            end else if (w_wait) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
            if (w_state_next == ST_HALT) begin
                r_halted <= 1'b1;
            end
            if (w_state_next == ST_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: builds an expected per-cycle trace from instruction-level rules
// and checks two controllers (HALT_EN=1 and HALT_EN=0) against it every cycle.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ifetch;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] rw_sel;
        logic       halted;
        logic       illegal;
    } ctl_t;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          br;
        logic [6:0]  op;
        ctl_t        e;
        logic [31:0] instret;
        bit          nh_illegal;
        bit          lit_en;
        logic [31:0] lit;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_we, mem_is_ifetch, ir_we, pc_we, alu_src, reg_write, halted, illegal;
    logic [1:0]  pc_sel, alu_op, rw_sel;
    logic [31:0] instret;
    logic        mem_req2, mem_we2, mem_is_ifetch2, ir_we2, pc_we2, alu_src2, reg_write2, halted2, illegal2;
    logic [1:0]  pc_sel2, alu_op2, rw_sel2;
    logic [31:0] instret2;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYC(8), .CNT_W(32), .HALT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_ifetch(mem_is_ifetch), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_src(alu_src), .alu_op(alu_op),
        .reg_write(reg_write), .rw_sel(rw_sel), .halted(halted), .illegal(illegal),
        .instret(instret)
    );

    multicycle_controller #(.TIMEOUT_CYC(8), .CNT_W(32), .HALT_EN(0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_is_ifetch(mem_is_ifetch2), .ir_we(ir_we2),
        .pc_we(pc_we2), .pc_sel(pc_sel2), .alu_src(alu_src2), .alu_op(alu_op2),
        .reg_write(reg_write2), .rw_sel(rw_sel2), .halted(halted2), .illegal(illegal2),
        .instret(instret2)
    );

    cyc_t        plan[$];
    cyc_t        cur;
    bit          cur_valid = 0;
    int          cyc_idx = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          m_instret = 0;
    bit          m_halted = 0;
    bit          m_illegal = 0;
    bit          m_nh_illegal = 0;
    bit          pend_lit = 0;
    logic [31:0] pend_val = 0;

    // ---------------- expected-trace builder ----------------
    task automatic push(input bit rdy, input bit br, input logic [6:0] op, input ctl_t e);
        cyc_t c;
        e.halted     = m_halted;
        e.illegal    = m_illegal;
        c.rst        = 0;
        c.ready      = rdy;
        c.br         = br;
        c.op         = op;
        c.e          = e;
        c.instret    = 32'(m_instret);
        c.nh_illegal = m_nh_illegal;
        c.lit_en     = pend_lit;
        c.lit        = pend_val;
        pend_lit     = 0;
        plan.push_back(c);
    endtask

    task automatic do_reset(input int n);
        cyc_t c;
        m_instret = 0; m_halted = 0; m_illegal = 0; m_nh_illegal = 0;
        for (int i = 0; i < n; i++) begin
            c.rst = 1; c.ready = 0; c.br = 0; c.op = 7'd0; c.e = '0;
            c.instret = 32'd0; c.nh_illegal = 0; c.lit_en = 0; c.lit = 0;
            plan.push_back(c);
        end
    endtask

    task automatic fetch(input int waits);
        ctl_t e;
        e = '0; e.mem_req = 1; e.ifetch = 1;
        for (int i = 0; i < waits; i++) push(0, 0, 7'd0, e);
        e.ir_we = 1; e.pc_we = 1; e.pc_sel = 2'b00;
        push(1, 0, 7'd0, e);
    endtask

    task automatic hold(input int n, input bit rdy);
        for (int i = 0; i < n; i++) push(rdy, 0, 7'd0, '0);
    endtask

    task automatic wb(input logic [6:0] op, input logic [1:0] rw);
        ctl_t e;
        e = '0; e.reg_write = 1; e.rw_sel = rw;
        push(0, 0, op, e);
        m_instret++;
    endtask

    task automatic mem_phase(input logic [6:0] op, input int waits, input bit we, input bit abort);
        ctl_t e;
        e = '0; e.mem_req = 1; e.mem_we = we;
        for (int i = 0; i < waits; i++) push(0, 0, op, e);
        if (!abort) begin
            push(1, 0, op, e);
            if (we) m_instret++;
        end
    endtask

    task automatic instr(input logic [6:0] op, input bit br, input int fw, input int mw, input bit abort);
        ctl_t e;
        fetch(fw);
        push(0, 0, op, '0);
        e = '0;
        case (op)
            7'b0110011: begin e.alu_op = 2'b10; push(0, 0, op, e); wb(op, 2'b00); end
            7'b0010011: begin e.alu_src = 1; e.alu_op = 2'b10; push(0, 0, op, e); wb(op, 2'b00); end
            7'b0000011: begin
                e.alu_src = 1; push(0, 0, op, e);
                mem_phase(op, mw, 0, abort);
                if (!abort) wb(op, 2'b01);
            end
            7'b0100011: begin e.alu_src = 1; push(0, 0, op, e); mem_phase(op, mw, 1, abort); end
            7'b1100011: begin
                e.alu_op = 2'b01;
                if (br) begin e.pc_we = 1; e.pc_sel = 2'b01; end
                push(0, br, op, e); m_instret++;
            end
            7'b1101111: begin
                e.reg_write = 1; e.rw_sel = 2'b10; e.pc_we = 1; e.pc_sel = 2'b01;
                push(0, 0, op, e); m_instret++;
            end
            7'b1100111: begin
                e.alu_src = 1; e.reg_write = 1; e.rw_sel = 2'b10; e.pc_we = 1; e.pc_sel = 2'b10;
                push(0, 0, op, e); m_instret++;
            end
            7'b1111111: begin m_halted = 1; m_nh_illegal = 1; end
            default:    begin m_illegal = 1; m_nh_illegal = 1; end
        endcase
    endtask

    task automatic chk_lat(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s trace cycles got=%0d want=%0d", name, got, want);
        end else begin
            $display("[TB] %s latency %0d cycles", name, got);
        end
    endtask

    task automatic build();
        int n0;
        ctl_t e;
        do_reset(2);
        n0 = plan.size(); instr(7'b0110011, 0, 0, 0, 0); chk_lat("add", plan.size() - n0, 4);
        pend_lit = 1; pend_val = 32'd1;
        n0 = plan.size(); instr(7'b0000011, 0, 0, 3, 0); chk_lat("lw_wait3", plan.size() - n0, 8);
        n0 = plan.size(); instr(7'b1100011, 1, 0, 0, 0); chk_lat("beq_taken", plan.size() - n0, 3);
        instr(7'b1100011, 0, 0, 0, 0);
        n0 = plan.size(); instr(7'b1101111, 0, 0, 0, 0); chk_lat("jal", plan.size() - n0, 3);
        n0 = plan.size(); instr(7'b1100111, 0, 0, 0, 0); chk_lat("jalr", plan.size() - n0, 3);
        n0 = plan.size(); instr(7'b0100011, 0, 2, 0, 0); chk_lat("sw_fwait2", plan.size() - n0, 6);
        n0 = plan.size(); instr(7'b0010011, 0, 0, 0, 0); chk_lat("addi", plan.size() - n0, 4);
        n0 = plan.size(); instr(7'b0010011, 0, 7, 0, 0); chk_lat("addi_fwait7", plan.size() - n0, 11);
        pend_lit = 1; pend_val = 32'd9;
        instr(7'b0000011, 0, 0, 2, 1);
        do_reset(1);
        // fetch starved: eight request cycles, then terminal trap ignoring mem_ready
        e = '0; e.mem_req = 1; e.ifetch = 1;
        for (int i = 0; i < 8; i++) push(0, 0, 7'd0, e);
        m_illegal = 1; m_nh_illegal = 1;
        hold(3, 1);
        do_reset(1);
        instr(7'b0110011, 0, 0, 0, 0);
        instr(7'b1111111, 0, 0, 0, 0);
        hold(2, 1);
        pend_lit = 1; pend_val = 32'd1;
        hold(1, 1);
        do_reset(1);
        instr(7'b0000000, 0, 0, 0, 0);
        hold(3, 1);
        do_reset(1);
        instr(7'b0110011, 0, 1, 0, 0);
        pend_lit = 1; pend_val = 32'd1;
        push(0, 0, 7'd0, ctl_t'{mem_req: 1'b1, ifetch: 1'b1, default: '0});
    endtask

    // ---------------- driver ----------------
    initial begin
        build();
        @(posedge clk);
        foreach (plan[k]) begin
            @(posedge clk);
            #1;
            rst_n     = !plan[k].rst;
            mem_ready = plan[k].ready;
            br_taken  = plan[k].br;
            opcode    = plan[k].op;
            cur       = plan[k];
            cyc_idx   = k;
            cur_valid = 1;
        end
        @(posedge clk);
        #1 cur_valid = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        ctl_t a, a2, e2;
        if (cur_valid) begin
            a  = {mem_req, mem_we, mem_is_ifetch, ir_we, pc_we, pc_sel, alu_src, alu_op,
                  reg_write, rw_sel, halted, illegal};
            a2 = {mem_req2, mem_we2, mem_is_ifetch2, ir_we2, pc_we2, pc_sel2, alu_src2, alu_op2,
                  reg_write2, rw_sel2, halted2, illegal2};
            e2 = cur.e;
            e2.halted  = 1'b0;
            e2.illegal = cur.nh_illegal;
            $display("[TB] cyc %0d rst=%0b rdy=%0b br=%0b op=%b ctl=%h instret=%0d",
                     cyc_idx, cur.rst, cur.ready, cur.br, cur.op, a, instret);
            n_tests++;
            if (a !== cur.e) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d got=%h want=%h", cyc_idx, a, cur.e);
            end
            n_tests++;
            if (instret !== cur.instret) begin
                n_fail++;
                $display("FAIL instret cyc=%0d got=%0d want=%0d", cyc_idx, instret, cur.instret);
            end
            n_tests++;
            if (a2 !== e2 || instret2 !== cur.instret) begin
                n_fail++;
                $display("FAIL ctl_nohalt cyc=%0d got=%h/%0d want=%h/%0d",
                         cyc_idx, a2, instret2, e2, cur.instret);
            end
            if (cur.lit_en) begin
                n_tests++;
                if (instret !== cur.lit) begin
                    n_fail++;
                    $display("FAIL instret_pin cyc=%0d got=%0d want=%0d", cyc_idx, instret, cur.lit);
                end
            end
        end
    end

endmodule
